// File: rtl/datamem_arbiter.sv
// -----------------------------------------------------------------------------
// datamem_arbiter
//
// Two-port round-robin arbiter and sequencer in front of a single-port,
// word-addressed data memory. Each access walks IDLE -> ACCESS -> DONE:
// the request is sampled in IDLE, the memory strobe is driven for exactly
// one cycle in ACCESS, and the requesting port gets a one-cycle ack in DONE.
//
// Optional feature (compile-time macro): DATAMEM_ARB_RANGECHK_EN
//   defined   : word addresses >= RAM_SIZE are not passed to memory; the ack
//               carries err = 1 and a read returns 0.
//   undefined : every access goes to memory unchanged, m0_err/m1_err stay 0.
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous, active-low reset
//   m0_req/m0_wr        port 0 request level / direction (1 = write)
//   m0_addr/m0_wdata    port 0 byte address / write data, held with req
//   m0_ack              port 0 one-cycle completion pulse
//   m0_rdata            port 0 read data register (valid with ack on a read)
//   m0_err              port 0 out-of-range flag (valid with ack)
//   m1_*                identical set for port 1
//   mem_rd/mem_wr       memory read / write enable, high only in ACCESS
//   mem_addr/mem_wdata  memory byte address / write data, held between accesses
//   mem_rdata           memory combinational read data
// -----------------------------------------------------------------------------
module datamem_arbiter #(
    parameter int RAM_SIZE = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

`ifdef DATAMEM_ARB_RANGECHK_EN
    localparam logic RANGECHK_EN = 1'b1;
`else
    localparam logic RANGECHK_EN = 1'b0;
`endif

    localparam logic [31:0] RAM_WORDS = 32'(RAM_SIZE);

    // True when the word index of a byte address lies beyond the memory depth.
    function automatic logic addr_out_of_range(input logic [31:0] addr);
        return ({2'b00, addr[31:2]} >= RAM_WORDS);
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic        r_last;      // port granted most recently
    logic        r_sel;       // port owning the transaction in flight
    logic        r_dir;       // 1 = write
    logic        r_oor;       // transaction in flight is out of range

    logic        w_any;
    logic        w_win;
    logic        w_win_wr;
    logic [31:0] w_win_addr;
    logic [31:0] w_win_wdata;
    logic        w_oor;
    logic [31:0] w_rd_value;

    // Winner selection: a lone requester wins, a tie goes to the port not granted last.
    always_comb begin
        w_any       = m0_req | m1_req;
        w_win       = 1'b0;
        w_win_wr    = 1'b0;
        w_win_addr  = 32'd0;
        w_win_wdata = 32'd0;
        if (m0_req && m1_req) begin
            w_win = ~r_last;
        end else begin
            w_win = m1_req;
        end
        if (w_win) begin
            w_win_wr    = m1_wr;
            w_win_addr  = m1_addr;
            w_win_wdata = m1_wdata;
        end else begin
            w_win_wr    = m0_wr;
            w_win_addr  = m0_addr;
            w_win_wdata = m0_wdata;
        end
        w_oor      = RANGECHK_EN & addr_out_of_range(w_win_addr);
        // An out-of-range read completes with zero data instead of memory contents.
        w_rd_value = r_oor ? 32'd0 : mem_rdata;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: sampling only happens in IDLE, the other states are one cycle each.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next = ACCESS;
                end else begin
                    w_next = IDLE;
                end
            end
            ACCESS:  w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath and registered outputs: latch the grant, strobe memory, return data and ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last    <= 1'b1;
            r_sel     <= 1'b0;
            r_dir     <= 1'b0;
            r_oor     <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;
            m0_rdata  <= 32'd0;
            m1_rdata  <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    m0_err <= 1'b0;
                    m1_err <= 1'b0;
                    if (w_any) begin
                        r_sel     <= w_win;
                        r_last    <= w_win;
                        r_dir     <= w_win_wr;
                        r_oor     <= w_oor;
                        mem_addr  <= w_win_addr;
                        mem_wdata <= w_win_wdata;
                        // Strobes are registered so they cover exactly the ACCESS cycle;
                        // an out-of-range access walks the FSM without touching memory.
                        mem_rd    <= ~w_win_wr & ~w_oor;
                        mem_wr    <= w_win_wr & ~w_oor;
                    end else begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                    end
                end
                ACCESS: begin
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    m0_ack <= ~r_sel;
                    m1_ack <= r_sel;
                    m0_err <= ~r_sel & r_oor;
                    m1_err <= r_sel & r_oor;
                    // Only the owning port's rdata register moves, and only on a read.
                    if (!r_dir) begin
                        if (r_sel) begin
                            m1_rdata <= w_rd_value;
                        end else begin
                            m0_rdata <= w_rd_value;
                        end
                    end else begin
                        m0_rdata <= m0_rdata;
                    end
                end
                DONE: begin
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    m0_err <= 1'b0;
                    m1_err <= 1'b0;
                end
                default: begin
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    m0_err <= 1'b0;
                    m1_err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_datamem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_datamem_arbiter
//
// Directed, self-checking bench for datamem_arbiter. A behavioural memory sits
// on the mem_* side. Every issued request pushes its expected completion
// (port, mem address, direction, read data, err, memory activity) onto a
// scoreboard queue; the entry is popped and compared when an ack appears.
// -----------------------------------------------------------------------------
module tb_datamem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          port;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] rdata;
        bit          err;
        int          act;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] exp_mem [256];
    logic [31:0] cur_rdata [2];

    always #5 clk = ~clk;

    datamem_arbiter #(.RAM_SIZE(256)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural memory: unwritten words read back a recognisable pattern.
    function automatic logic [31:0] init_val(input logic [7:0] idx);
        return {24'hA50000, idx};
    endfunction

    logic [31:0] mem_a [256];
    bit          mem_v [256];

    always @(posedge clk) begin
        if (mem_wr) begin
            mem_a[mem_addr[9:2]] <= mem_wdata;
            mem_v[mem_addr[9:2]] <= 1'b1;
        end
    end

    assign mem_rdata = mem_v[mem_addr[9:2]] ? mem_a[mem_addr[9:2]] : init_val(mem_addr[9:2]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input bit rq, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            m0_req = rq; m0_wr = wr; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = rq; m1_wr = wr; m1_addr = a; m1_wdata = d;
        end
    endtask

    // Predict the completion of one request and queue it in service order.
    task automatic push(input int p, input bit wr, input logic [31:0] a, input logic [31:0] d);
        sb_t e;
        bit  oor;
`ifdef DATAMEM_ARB_RANGECHK_EN
        oor = (a[31:2] >= 30'd256);
`else
        oor = 1'b0;
`endif
        e.port  = p;
        e.wr    = wr;
        e.addr  = a;
        e.err   = oor;
        e.act   = oor ? 0 : 1;
        e.rdata = oor ? 32'd0 : exp_mem[a[9:2]];
        if (wr && !oor) exp_mem[a[9:2]] = d;
        sb.push_back(e);
    endtask

    task automatic issue(input int p, input bit wr, input logic [31:0] a, input logic [31:0] d);
        push(p, wr, a, d);
        drive(p, 1'b1, wr, a, d);
    endtask

    // Wait (bounded) for the next ack, checking memory strobes on the way and
    // the completion against the head of the scoreboard.
    task automatic wait_ack(input string tag, input int exp_wait, input bit keep);
        int  n;
        int  act;
        bit  got;
        sb_t e;
        n = 0; act = 0; got = 1'b0;
        e.port = 0; e.wr = 1'b0; e.addr = 32'd0; e.rdata = 32'd0; e.err = 1'b0; e.act = 0;
        if (sb.size() > 0) e = sb[0];
        while (!got && n < 12) begin
            @(negedge clk);
            n++;
            if (mem_rd || mem_wr) begin
                act++;
                chk({tag, "_mem_addr"}, mem_addr, e.addr);
                chk({tag, "_mem_wr"}, {31'd0, mem_wr}, {31'd0, e.wr});
            end
            if (m0_ack || m1_ack) got = 1'b1;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_wait));
        chk({tag, "_mem_cycles"}, 32'(act), 32'(e.act));
        if (got) begin
            if (sb.size() == 0) begin
                chk({tag, "_unexpected_ack"}, 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk({tag, "_port"}, {31'd0, m1_ack}, 32'(e.port));
                chk({tag, "_single_ack"}, {31'd0, m0_ack & m1_ack}, 32'd0);
                chk({tag, "_err"}, {31'd0, (e.port == 0) ? m0_err : m1_err}, {31'd0, e.err});
                if (!e.wr) cur_rdata[e.port] = e.rdata;
                chk({tag, "_m0_rdata"}, m0_rdata, cur_rdata[0]);
                chk({tag, "_m1_rdata"}, m1_rdata, cur_rdata[1]);
                if (!keep) begin
                    if (e.port == 0) m0_req = 1'b0;
                    else             m1_req = 1'b0;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) exp_mem[i] = init_val(8'(i));
        cur_rdata[0] = 32'd0;
        cur_rdata[1] = 32'd0;
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
        chk("rst_errs", {30'd0, m0_err, m1_err}, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Port 0 write, then port 1 reads it back.
        issue(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        wait_ack("m0_write", 2, 1'b0);
        @(negedge clk);
        issue(1, 1'b0, 32'h0000_0010, 32'd0);
        wait_ack("m1_read", 2, 1'b0);
        @(negedge clk);

        // Read beyond the memory depth (word 256).
        issue(0, 1'b0, 32'h0000_0400, 32'd0);
        wait_ack("m0_range", 2, 1'b0);
        @(negedge clk);

        // Port 0 holds req for back-to-back reads of 0x0 then 0x4.
        issue(0, 1'b0, 32'h0000_0000, 32'd0);
        wait_ack("b2b_first", 2, 1'b1);
        push(0, 1'b0, 32'h0000_0004, 32'd0);
        m0_addr = 32'h0000_0004;
        wait_ack("b2b_second", 3, 1'b0);
        @(negedge clk);

        // Reset during the ACCESS cycle of a write: strobe drops, write lost, no ack.
        drive(0, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678);
        @(negedge clk);
        chk("abort_mem_wr_before", {31'd0, mem_wr}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort_mem_wr_async", {31'd0, mem_wr}, 32'd0);
        chk("abort_mem_rd_async", {31'd0, mem_rd}, 32'd0);
        m0_req = 1'b0;
        @(negedge clk);
        chk("abort_no_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
        reset = 1'b1;
        cur_rdata[0] = 32'd0;
        cur_rdata[1] = 32'd0;
        chk("abort_m0_rdata_cleared", m0_rdata, 32'd0);
        chk("abort_m1_rdata_cleared", m1_rdata, 32'd0);
        @(negedge clk);
        chk("abort_still_no_ack", {30'd0, m0_ack, m1_ack}, 32'd0);

        // Both ports request right after reset and keep requesting: 0, 1, 0, 1.
        push(0, 1'b0, 32'h0000_0020, 32'd0);
        push(1, 1'b0, 32'h0000_0010, 32'd0);
        push(0, 1'b0, 32'h0000_0020, 32'd0);
        push(1, 1'b0, 32'h0000_0010, 32'd0);
        drive(0, 1'b1, 1'b0, 32'h0000_0020, 32'd0);
        drive(1, 1'b1, 1'b0, 32'h0000_0010, 32'd0);
        wait_ack("rr_1st", 2, 1'b1);
        wait_ack("rr_2nd", 3, 1'b1);
        wait_ack("rr_3rd", 3, 1'b1);
        wait_ack("rr_4th", 3, 1'b0);
        m0_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_idle_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
